// File: rtl/cluster_dma_frontend_arbiter_if.sv
// Request/backend bundle between the per-core DMA frontends, the arbiter and the DMA backend.
// The slave modport is the arbiter's view; the master modport drives requests and backend responses.
// Widths follow the arbiter parameters so both sides agree on packing.
interface cluster_dma_frontend_arbiter_if #(
  parameter int NumReq         = 4,
  parameter int IdWidth        = 8,
  parameter int PayloadWidth   = 64,
  parameter int MaxOutstanding = 8
);
  localparam int CntW = $clog2(MaxOutstanding + 1);

  logic [NumReq-1:0]              req_valid_i;
  logic [NumReq-1:0]              req_ready_o;
  logic [NumReq*PayloadWidth-1:0] req_payload_i;
  logic [IdWidth-1:0]             req_id_o;
  logic                           be_valid_o;
  logic                           be_ready_i;
  logic [PayloadWidth-1:0]        be_payload_o;
  logic [IdWidth-1:0]             be_id_o;
  logic                           retire_i;
  logic [IdWidth-1:0]             completed_id_o;
  logic [CntW-1:0]                outstanding_o;
  logic                           idle_o;

  modport slave (
    input  req_valid_i, req_payload_i, be_ready_i, retire_i,
    output req_ready_o, req_id_o, be_valid_o, be_payload_o, be_id_o,
           completed_id_o, outstanding_o, idle_o
  );

  modport master (
    output req_valid_i, req_payload_i, be_ready_i, retire_i,
    input  req_ready_o, req_id_o, be_valid_o, be_payload_o, be_id_o,
           completed_id_o, outstanding_o, idle_o
  );
endinterface

// File: rtl/cluster_dma_frontend_arbiter.sv
// Round-robin share of one DMA backend among NumReq requesters, with wrapping transfer IDs and in-flight tracking.
// Latency: zero -- grant, ID and payload are combinational; counters update on the issuing/retiring edge.
// Backpressure: be_ready_i low holds (locks) the current winner; at MaxOutstanding in flight no grants are made.
module cluster_dma_frontend_arbiter #(
  parameter int NumReq         = 4,
  parameter int IdWidth        = 8,
  parameter int PayloadWidth   = 64,
  parameter int MaxOutstanding = 8
) (
  input logic                          clk_i,
  input logic                          rst_ni,
  cluster_dma_frontend_arbiter_if.slave bus
);

  localparam int CntW = $clog2(MaxOutstanding + 1);
  localparam int PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  typedef logic [IdWidth-1:0] id_t;

  // ID 0 means "no transfer", so the sequence skips it when wrapping.
  function automatic id_t id_inc(input id_t id);
    return (&id) ? IdWidth'(1) : id + IdWidth'(1);
  endfunction

  // Requester index 'off' positions after 'base', wrapping at NumReq.
  function automatic logic [PtrW-1:0] rr_idx(input logic [PtrW-1:0] base, input int off);
    int s;
    s = int'(base) + off;
    if (s >= NumReq) s = s - NumReq;
    return PtrW'(s);
  endfunction

  id_t             next_id_q, next_id_d;
  id_t             completed_id_q, completed_id_d;
  logic [CntW-1:0] outstanding_q, outstanding_d;
  logic [PtrW-1:0] rr_q, rr_d;
  logic            lock_q, lock_d;
  logic [PtrW-1:0] lock_idx_q, lock_idx_d;

  logic              winner_exists;
  logic [PtrW-1:0]   winner_idx;
  logic              full;
  logic              be_valid;
  logic              issue;
  logic              retire_ok;
  logic [NumReq-1:0] req_ready;

  // Winner selection: a locked winner is held; otherwise first valid requester at or after rr_q.
  // A locked requester that drops valid yields no winner this cycle and the lock is released.
  always_comb begin
    winner_exists = 1'b0;
    winner_idx    = '0;
    if (lock_q) begin
      if (bus.req_valid_i[lock_idx_q]) begin
        winner_exists = 1'b1;
        winner_idx    = lock_idx_q;
      end
    end else begin
      for (int i = NumReq - 1; i >= 0; i--) begin
        if (bus.req_valid_i[rr_idx(rr_q, i)]) begin
          winner_exists = 1'b1;
          winner_idx    = rr_idx(rr_q, i);
        end
      end
    end
  end

  // Handshake: be_valid depends only on state and requests, never on be_ready_i.
  always_comb begin
    full      = (outstanding_q == CntW'(MaxOutstanding));
    be_valid  = winner_exists && !full;
    issue     = be_valid && bus.be_ready_i;
    retire_ok = bus.retire_i && (outstanding_q != '0);
    req_ready = '0;
    if (issue) req_ready[winner_idx] = 1'b1;
  end

  // Next-state for ID counters, in-flight count, round-robin pointer and lock.
  always_comb begin
    next_id_d      = next_id_q;
    completed_id_d = completed_id_q;
    outstanding_d  = outstanding_q;
    rr_d           = rr_q;
    lock_d         = be_valid && !bus.be_ready_i;
    lock_idx_d     = winner_idx;
    if (issue) begin
      next_id_d = id_inc(next_id_q);
      rr_d      = (winner_idx == PtrW'(NumReq - 1)) ? '0 : winner_idx + PtrW'(1);
    end
    if (retire_ok) completed_id_d = id_inc(completed_id_q);
    unique case ({issue, retire_ok})
      2'b10:   outstanding_d = outstanding_q + CntW'(1);
      2'b01:   outstanding_d = outstanding_q - CntW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // State registers; reset drops every in-flight ID.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      next_id_q      <= IdWidth'(1);
      completed_id_q <= '0;
      outstanding_q  <= '0;
      rr_q           <= '0;
      lock_q         <= 1'b0;
      lock_idx_q     <= '0;
    end else begin
      next_id_q      <= next_id_d;
      completed_id_q <= completed_id_d;
      outstanding_q  <= outstanding_d;
      rr_q           <= rr_d;
      lock_q         <= lock_d;
      lock_idx_q     <= lock_idx_d;
    end
  end

  assign bus.req_ready_o    = req_ready;
  assign bus.req_id_o       = next_id_q;
  assign bus.be_id_o        = next_id_q;
  assign bus.be_valid_o     = be_valid;
  assign bus.be_payload_o   = be_valid ? bus.req_payload_i[int'(winner_idx)*PayloadWidth +: PayloadWidth]
                                       : '0;
  assign bus.completed_id_o = completed_id_q;
  assign bus.outstanding_o  = outstanding_q;
  assign bus.idle_o         = (outstanding_q == '0) && !(|bus.req_valid_i);

  // Protocol checks: a locked requester must keep valid up; retire needs something in flight.
  a_lock_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    lock_q |-> bus.req_valid_i[lock_idx_q])
    else $warning("locked requester dropped valid before grant");

  a_retire_nonempty: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bus.retire_i |-> (outstanding_q != '0))
    else $warning("retire with nothing outstanding ignored");

endmodule

// File: tb/tb_cluster_dma_frontend_arbiter.sv
module tb_cluster_dma_frontend_arbiter;

  logic clk_i;
  logic rst_ni;
  int   checks;
  int   failures;

  cluster_dma_frontend_arbiter_if #(.NumReq(4), .IdWidth(8), .PayloadWidth(64), .MaxOutstanding(8)) bus_a ();
  cluster_dma_frontend_arbiter_if #(.NumReq(2), .IdWidth(3), .PayloadWidth(8),  .MaxOutstanding(6)) bus_b ();

  cluster_dma_frontend_arbiter #(.NumReq(4), .IdWidth(8), .PayloadWidth(64), .MaxOutstanding(8)) dut_a (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus_a)
  );

  cluster_dma_frontend_arbiter #(.NumReq(2), .IdWidth(3), .PayloadWidth(8), .MaxOutstanding(6)) dut_b (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .bus   (bus_b)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [3:0] vld;
    logic       rdy;
    logic       ret;
    logic       e_bev;
    logic [3:0] e_rdy;
    logic [7:0] e_id;
    logic [3:0] e_out;
    logic [7:0] e_cmp;
    logic       e_idle;
    int         e_pl;   // expected payload source requester, -1 for zero
  } vec_t;

  vec_t vt[$];

  function automatic logic [63:0] pl(input int i);
    return 64'hD0A0_0000_5555_0000 + 64'(i) * 64'h0000_0001_0000_0001;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] vld, input logic rdy, input logic ret,
                     input logic bev, input logic [3:0] erdy, input logic [7:0] id,
                     input logic [3:0] out, input logic [7:0] cmp, input logic idle, input int epl);
    vec_t v;
    v.vld = vld; v.rdy = rdy; v.ret = ret; v.e_bev = bev; v.e_rdy = erdy; v.e_id = id;
    v.e_out = out; v.e_cmp = cmp; v.e_idle = idle; v.e_pl = epl;
    vt.push_back(v);
  endtask

  logic [63:0] exp_pl;
  logic [2:0]  id_tab [9];

  initial begin
    checks   = 0;
    failures = 0;
    rst_ni   = 1'b0;
    bus_a.req_valid_i = '0;
    bus_a.be_ready_i  = 1'b0;
    bus_a.retire_i    = 1'b0;
    for (int i = 0; i < 4; i++) bus_a.req_payload_i[i*64 +: 64] = pl(i);
    bus_b.req_valid_i   = '0;
    bus_b.be_ready_i    = 1'b0;
    bus_b.retire_i      = 1'b0;
    bus_b.req_payload_i = 16'h5AA5;

    //        vld    rdy  ret  bev erdy   id     out  cmp    idle pl
    add(4'hF, 1, 0,  1, 4'h1, 8'd1, 4'd0, 8'd0, 0,  0);   // round-robin sweep 0..3
    add(4'hF, 1, 0,  1, 4'h2, 8'd2, 4'd1, 8'd0, 0,  1);
    add(4'hF, 1, 0,  1, 4'h4, 8'd3, 4'd2, 8'd0, 0,  2);
    add(4'hF, 1, 0,  1, 4'h8, 8'd4, 4'd3, 8'd0, 0,  3);
    add(4'h0, 0, 0,  0, 4'h0, 8'd5, 4'd4, 8'd0, 0, -1);
    add(4'h4, 0, 0,  1, 4'h0, 8'd5, 4'd4, 8'd0, 0,  2);   // req2 stalled by backend
    add(4'h4, 0, 0,  1, 4'h0, 8'd5, 4'd4, 8'd0, 0,  2);
    add(4'h4, 0, 0,  1, 4'h0, 8'd5, 4'd4, 8'd0, 0,  2);
    add(4'h5, 0, 0,  1, 4'h0, 8'd5, 4'd4, 8'd0, 0,  2);   // req0 appears, lock keeps req2
    add(4'h5, 1, 0,  1, 4'h4, 8'd5, 4'd4, 8'd0, 0,  2);   // req2 issues first
    add(4'h1, 1, 0,  1, 4'h1, 8'd6, 4'd5, 8'd0, 0,  0);   // then req0
    add(4'h0, 0, 1,  0, 4'h0, 8'd7, 4'd6, 8'd0, 0, -1);   // retires
    add(4'h0, 0, 1,  0, 4'h0, 8'd7, 4'd5, 8'd1, 0, -1);
    add(4'h0, 0, 1,  0, 4'h0, 8'd7, 4'd4, 8'd2, 0, -1);
    add(4'h2, 1, 1,  1, 4'h2, 8'd7, 4'd3, 8'd3, 0,  1);   // issue+retire at 3
    add(4'h0, 0, 1,  0, 4'h0, 8'd8, 4'd3, 8'd4, 0, -1);   // still 3
    add(4'h0, 0, 1,  0, 4'h0, 8'd8, 4'd2, 8'd5, 0, -1);
    add(4'h0, 0, 1,  0, 4'h0, 8'd8, 4'd1, 8'd6, 0, -1);
    add(4'h0, 0, 1,  0, 4'h0, 8'd8, 4'd0, 8'd7, 1, -1);   // retire at 0 ignored
    add(4'h0, 0, 0,  0, 4'h0, 8'd8, 4'd0, 8'd7, 1, -1);

    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_be_valid", 64'(bus_a.be_valid_o), 64'd0);
    chk("rst_req_id", 64'(bus_a.req_id_o), 64'd1);
    chk("rst_be_id", 64'(bus_a.be_id_o), 64'd1);
    chk("rst_completed", 64'(bus_a.completed_id_o), 64'd0);
    chk("rst_outstanding", 64'(bus_a.outstanding_o), 64'd0);
    chk("rst_idle", 64'(bus_a.idle_o), 64'd1);
    chk("rst_req_ready", 64'(bus_a.req_ready_o), 64'd0);
    chk("rst_payload", bus_a.be_payload_o, 64'd0);

    // Table vectors: drive after the falling edge, check before the next rising edge.
    for (int k = 0; k < vt.size(); k++) begin
      @(negedge clk_i);
      bus_a.req_valid_i = vt[k].vld;
      bus_a.be_ready_i  = vt[k].rdy;
      bus_a.retire_i    = vt[k].ret;
      #1;
      exp_pl = (vt[k].e_pl < 0) ? 64'd0 : pl(vt[k].e_pl);
      chk($sformatf("v%0d_be_valid", k), 64'(bus_a.be_valid_o), 64'(vt[k].e_bev));
      chk($sformatf("v%0d_req_ready", k), 64'(bus_a.req_ready_o), 64'(vt[k].e_rdy));
      chk($sformatf("v%0d_req_id", k), 64'(bus_a.req_id_o), 64'(vt[k].e_id));
      chk($sformatf("v%0d_be_id", k), 64'(bus_a.be_id_o), 64'(vt[k].e_id));
      chk($sformatf("v%0d_outstanding", k), 64'(bus_a.outstanding_o), 64'(vt[k].e_out));
      chk($sformatf("v%0d_completed", k), 64'(bus_a.completed_id_o), 64'(vt[k].e_cmp));
      chk($sformatf("v%0d_idle", k), 64'(bus_a.idle_o), 64'(vt[k].e_idle));
      chk($sformatf("v%0d_payload", k), bus_a.be_payload_o, exp_pl);
    end

    // Fill to MaxOutstanding with req3 streaming; the 9th request must wait.
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i);
      bus_a.req_valid_i = 4'h8;
      bus_a.be_ready_i  = 1'b1;
      bus_a.retire_i    = 1'b0;
      #1;
      chk($sformatf("full%0d_outstanding", k), 64'(bus_a.outstanding_o), 64'(k));
      if (k < 8) begin
        chk($sformatf("full%0d_be_valid", k), 64'(bus_a.be_valid_o), 64'd1);
        chk($sformatf("full%0d_req_ready", k), 64'(bus_a.req_ready_o), 64'h8);
        chk($sformatf("full%0d_req_id", k), 64'(bus_a.req_id_o), 64'(8 + k));
      end else begin
        chk("full8_be_valid", 64'(bus_a.be_valid_o), 64'd0);
        chk("full8_req_ready", 64'(bus_a.req_ready_o), 64'd0);
      end
    end
    @(negedge clk_i);
    bus_a.retire_i = 1'b1;
    #1;
    chk("full_retire_same_cycle_be_valid", 64'(bus_a.be_valid_o), 64'd0);
    @(negedge clk_i);
    bus_a.retire_i = 1'b0;
    #1;
    chk("after_retire_be_valid", 64'(bus_a.be_valid_o), 64'd1);
    chk("after_retire_req_ready", 64'(bus_a.req_ready_o), 64'h8);
    chk("after_retire_req_id", 64'(bus_a.req_id_o), 64'd16);
    chk("after_retire_outstanding", 64'(bus_a.outstanding_o), 64'd7);
    @(negedge clk_i);
    bus_a.req_valid_i = 4'h0;
    bus_a.be_ready_i  = 1'b0;
    #1;
    chk("refill_outstanding", 64'(bus_a.outstanding_o), 64'd8);
    chk("refill_completed", 64'(bus_a.completed_id_o), 64'd8);

    // Reset in the middle of operation takes effect without a clock edge.
    @(negedge clk_i);
    rst_ni = 1'b0;
    #1;
    chk("midrst_outstanding", 64'(bus_a.outstanding_o), 64'd0);
    chk("midrst_req_id", 64'(bus_a.req_id_o), 64'd1);
    chk("midrst_completed", 64'(bus_a.completed_id_o), 64'd0);
    chk("midrst_idle", 64'(bus_a.idle_o), 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;

    // Narrow IDs: 3-bit wrap skips 0, issue and completion sequences both follow it.
    id_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd1, 3'd2};
    for (int k = 0; k < 9; k++) begin
      @(negedge clk_i);
      bus_b.req_valid_i = 2'b01;
      bus_b.be_ready_i  = 1'b1;
      bus_b.retire_i    = (k > 0);
      #1;
      chk($sformatf("w%0d_req_id", k), 64'(bus_b.req_id_o), 64'(id_tab[k]));
      chk($sformatf("w%0d_req_ready", k), 64'(bus_b.req_ready_o), 64'h1);
      chk($sformatf("w%0d_completed", k), 64'(bus_b.completed_id_o), (k < 2) ? 64'd0 : 64'(id_tab[k-2]));
      chk($sformatf("w%0d_outstanding", k), 64'(bus_b.outstanding_o), (k == 0) ? 64'd0 : 64'd1);
    end
    @(negedge clk_i);
    bus_b.req_valid_i = 2'b00;
    bus_b.be_ready_i  = 1'b0;
    bus_b.retire_i    = 1'b1;
    #1;
    chk("w_last_completed", 64'(bus_b.completed_id_o), 64'(id_tab[7]));
    @(negedge clk_i);
    bus_b.retire_i = 1'b0;
    #1;
    chk("w_final_completed", 64'(bus_b.completed_id_o), 64'(id_tab[8]));
    chk("w_final_outstanding", 64'(bus_b.outstanding_o), 64'd0);
    chk("w_final_idle", 64'(bus_b.idle_o), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
